prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the pipelined CPU. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words (high byte first). It writes them sequentially into the instruction RAM that feeds the CPU's instruction port, verifies an XOR checksum, and only then releases the CPU with `enable` high and a one-cycle `start` pulse. It holds the CPU disabled for the whole load.

## Interface
- `ADDR_W`, default 8: instruction RAM address width; matches the CPU `i_addr` width.
- `TIMEOUT`, default 1000: consecutive idle receive cycles before the load is aborted; must be ≥ 2.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `load_req` in 1: request to start a load; sampled only in IDLE, DONE and ERR.
- `rx_data` in 8: incoming stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader can accept a byte this cycle.
- `im_addr` out ADDR_W: instruction RAM write address.
- `im_data` out 16: instruction RAM write data, as {hi, lo}.
- `im_we` out 1: instruction RAM write strobe, one cycle per word.
- `cpu_enable` out 1: drives CPU `enable`.
- `cpu_start` out 1: drives CPU `start`; one-cycle pulse.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load succeeded.
- `err` out 1: the last load aborted.
- `word_cnt` out ADDR_W+1: number of words written in the current or last load.

## Operation
- Frame format: LEN byte N, then N words (2 bytes each, high byte first), then CHK byte. N=0 means 2^ADDR_W words.
- CHK is the XOR of all 2N data bytes. LEN is not included in CHK.
- A byte is accepted when `rx_valid & rx_ready`.
- State machine: IDLE, LEN, HI, LO, WRITE, CHK, START, DONE, ERR.
- IDLE: `load_req` → LEN. Clear `word_cnt`, the XOR accumulator, the timeout counter, `done` and `err`. Drop `cpu_enable`.
- LEN: on accept, latch N → HI.
- HI: on accept, latch the high byte and XOR it into the accumulator → LO.
- LO: on accept, latch the low byte and XOR it → WRITE.
- WRITE: for one cycle, `im_we`=1, `im_addr`=`word_cnt`[ADDR_W-1:0], `im_data`={hi,lo}. Then increment `word_cnt`. If the new count equals N (256 when N=0) → CHK; else → HI.
- CHK: on accept, compare the byte to the accumulator. Match → START; mismatch → ERR.
- START: `cpu_start`=1 and `cpu_enable`=1 for one cycle → DONE.
- DONE: `done`=1 and `cpu_enable`=1 are held. `load_req` restarts the load (→ LEN, as from IDLE), and `cpu_enable` drops in the same cycle the transition occurs.
- ERR: `err`=1 is held, `cpu_enable`=0, `cpu_start` is never asserted. `load_req` → LEN.
- `rx_ready`=1 only in LEN, HI, LO and CHK. It is 0 in WRITE, giving one stall cycle per word.
- `busy`=1 in LEN, HI, LO, WRITE, CHK and START.
- Timeout: the counter increments each cycle spent in LEN/HI/LO/CHK without an accept. It clears on any accept and on entry to LEN. It holds (does not count) in WRITE. When it reaches `TIMEOUT` → ERR.
- Addresses never wrap within a load. The maximum of 2^ADDR_W words fills addresses 0..2^ADDR_W−1 exactly. `word_cnt` is ADDR_W+1 bits wide so it can hold 256.
- Bytes offered while `rx_ready`=0 are not consumed. The upstream source must hold them.

## Timing
- Reset (async assert, sync-released by the clock domain): state=IDLE. All outputs are 0: `rx_ready`, `im_we`, `im_addr`, `im_data`, `cpu_enable`, `cpu_start`, `busy`, `done`, `err` and `word_cnt`.
- Reset mid-load aborts immediately. The RAM is left partially written, the CPU stays disabled, and no `start` is issued.
- `load_req` seen in cycle t → state LEN and `rx_ready`=1 in cycle t+1.
- With `rx_valid` held high, each word takes 3 cycles (HI, LO, WRITE). A full load takes 1 (LEN) + 3N + 1 (CHK) + 1 (START) cycles after entering LEN.
- `cpu_start` asserts the cycle after the CHK byte is accepted. `cpu_enable` rises in the same cycle and stays high through DONE.
- `im_we` is registered: address and data are stable for the whole cycle in which `im_we`=1.
- If an accept and the timeout limit coincide in the same cycle, the accept wins and the counter clears.
- If `load_req` is asserted while `busy`=1, it is ignored.

## Test plan
- Reset mid-stream (assert during HI of word 1) → all outputs 0 at once, state IDLE; a subsequent `load_req` reloads cleanly from address 0.
- Stream N=2 with words 0x1234 and 0xABCD, CHK=0x12^0x34^0xAB^0xCD=0x40, `rx_valid` always high → writes (0,0x1234) and (1,0xABCD). `cpu_start` pulses once, 8 cycles after entering LEN. Then `done`=1, `cpu_enable`=1, `word_cnt`=2.
- Same frame with CHK=0x41 → `err`=1, `cpu_start` never asserts, `cpu_enable`=0, both words still written.
- N=0 (256 words), data = address → the last write is to address 255 and `word_cnt`=256 in DONE. No write ever occurs to address 0 a second time.
- `TIMEOUT`=10 and the stream stalls after the HI byte → ERR exactly 10 cycles after the last accept. Stalling for 9 cycles and then sending → no error.
- Random `rx_valid` gaps and a `load_req` pulse while busy → the written contents match the source, the extra `load_req` is ignored, and `cpu_start` pulses only once.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream receive handshake and instruction-RAM write port of the boot loader.
// rx handshake: a byte moves on every rising edge where rx_valid & rx_ready are both high.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_data;
    logic              im_we;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, im_addr, im_data, im_we
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, im_addr, im_data, im_we
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a LEN/words/CHK frame, fills the instruction RAM,
// checks the XOR checksum and only then enables and starts the CPU.
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clock,
    input  logic              reset,
    prog_loader_if.slave      bus,
    input  logic              load_req,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt,
    output logic [3:0]        dbg_state
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEN   = 4'd1,
        S_HI    = 4'd2,
        S_LO    = 4'd3,
        S_WRITE = 4'd4,
        S_CHK   = 4'd5,
        S_START = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              rx_ready;
    logic              accept;
    logic              rx_wait;
    logic [ADDR_W:0]   n_full;
    logic [ADDR_W:0]   cnt_inc;

    assign rx_ready = (state_q == S_LEN) || (state_q == S_HI) ||
                      (state_q == S_LO)  || (state_q == S_CHK);
    assign accept   = rx_ready & bus.rx_valid;
    assign rx_wait  = rx_ready & ~bus.rx_valid;
    // LEN of zero encodes a completely full RAM.
    assign n_full   = (len_q == 8'd0) ? MAX_WORDS : (ADDR_W+1)'(len_q);
    assign cnt_inc  = word_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        acc_d      = acc_q;
        len_d      = len_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        to_cnt_d   = to_cnt_q;

        if (accept) begin
            to_cnt_d = '0;
        end else if (rx_wait) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d    = S_LEN;
                    word_cnt_d = '0;
                    acc_d      = '0;
                    to_cnt_d   = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d   = bus.rx_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = bus.rx_data;
                    acc_d   = acc_q ^ bus.rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    lo_d    = bus.rx_data;
                    acc_d   = acc_q ^ bus.rx_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_cnt_d = cnt_inc;
                state_d    = (cnt_inc == n_full) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (bus.rx_data == acc_q) ? S_START : S_ERR;
                end
            end
            S_START: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // A cycle with an accept never times out, so only waiting cycles can abort.
        if (rx_wait && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
            state_d = S_ERR;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            acc_q      <= '0;
            len_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            acc_q      <= acc_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.im_we    = (state_q == S_WRITE);
    assign bus.im_addr  = word_cnt_q[ADDR_W-1:0];
    assign bus.im_data  = {hi_q, lo_q};

    // A reload request from DONE disables the CPU in the very cycle it is seen.
    assign cpu_enable = (state_q == S_START) || ((state_q == S_DONE) && !load_req);
    assign cpu_start  = (state_q == S_START);
    assign busy       = (state_q == S_LEN) || (state_q == S_HI) || (state_q == S_LO) ||
                        (state_q == S_WRITE) || (state_q == S_CHK) || (state_q == S_START);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign word_cnt   = word_cnt_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are driven byte by byte, expected RAM writes
// are queued as words are sent and compared when im_we fires.
module tb_prog_loader;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LEN  = 4'd1;
  localparam logic [3:0] S_HI   = 4'd2;
  localparam logic [3:0] S_LO   = 4'd3;
  localparam logic [3:0] S_DONE = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  logic       clock;
  logic       reset;
  logic       load_req;
  logic       cpu_enable;
  logic       cpu_start;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] word_cnt;
  logic [3:0] dbg_state;

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .TIMEOUT(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .load_req   (load_req),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];
  logic [15:0] src_q[$];
  int          cyc = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          len_cyc = 0;
  logic [3:0]  prev_state = 4'd0;
  logic [7:0]  last_addr = 8'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clock) begin
    if (bus.im_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {8'd0, bus.im_addr, bus.im_data}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("ram_write", {8'd0, bus.im_addr, bus.im_data}, {8'd0, e});
      end
      last_addr = bus.im_addr;
    end
    if (cpu_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (dbg_state == S_LEN && prev_state != S_LEN) len_cyc = cyc;
    prev_state = dbg_state;
  end

  // drivers
  task automatic pulse_load();
    @(posedge clock); #1 load_req = 1'b1;
    @(posedge clock); #1 load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (bus.rx_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] n, input logic [7:0] chk, input int max_gap);
    int cnt;
    cnt = (n == 8'd0) ? 256 : int'(n);
    send_byte(n, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({i[7:0], src_q[i]});
      send_byte(src_q[i][15:8], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
      send_byte(src_q[i][7:0],  (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
    send_byte(chk, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [7:0] chk;
    reset        = 1'b0;
    load_req     = 1'b0;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
    check("rst_outs", {bus.rx_ready, bus.im_we, cpu_enable, cpu_start, busy, done, err}, 32'd0);
    check("rst_bus", {bus.im_addr, bus.im_data, word_cnt}, 32'd0);
    reset = 1'b1;

    // reset during HI of word 1
    pulse_load();
    check("req_to_len", {27'd0, bus.rx_ready, dbg_state}, {27'd0, 1'b1, S_LEN});
    send_byte(8'd2, 0);
    exp_q.push_back({8'd0, 16'h1234});
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    bus.rx_valid = 1'b0;
    wait_state("reach_hi1", S_HI, 10);
    reset = 1'b0;
    #1;
    check("midrst_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
    check("midrst_outs", {bus.rx_ready, bus.im_we, cpu_enable, cpu_start, busy, done, err}, 32'd0);
    check("midrst_cnt", {23'd0, word_cnt}, 32'd0);
    check("midrst_q", exp_q.size(), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // N=2 good frame, rx_valid always high
    src_q = '{16'h1234, 16'hABCD};
    start_cnt = 0;
    pulse_load();
    send_frame(8'd2, 8'h40, 0);
    wait_state("good_done", S_DONE, 20);
    check("good_start_cnt", start_cnt, 32'd1);
    check("good_start_lat", start_cyc - len_cyc, 32'd8);
    check("good_flags", {done, cpu_enable, err, busy}, 32'b1100);
    check("good_wc", {23'd0, word_cnt}, 32'd2);
    check("good_q", exp_q.size(), 32'd0);

    // same frame with bad checksum
    start_cnt = 0;
    pulse_load();
    check("reload_en_drop", {31'd0, cpu_enable}, 32'd0);
    send_frame(8'd2, 8'h41, 0);
    wait_state("bad_err", S_ERR, 20);
    repeat (3) @(negedge clock);
    check("bad_start_cnt", start_cnt, 32'd0);
    check("bad_flags", {done, cpu_enable, err, busy}, 32'b0010);
    check("bad_wc", {23'd0, word_cnt}, 32'd2);
    check("bad_q", exp_q.size(), 32'd0);

    // N=0: 256 words, data = address
    src_q.delete();
    chk = 8'd0;
    for (int i = 0; i < 256; i++) begin
      src_q.push_back(16'(i));
      chk = chk ^ 8'(i);
    end
    start_cnt = 0;
    pulse_load();
    send_frame(8'd0, chk, 0);
    wait_state("full_done", S_DONE, 20);
    check("full_wc", {23'd0, word_cnt}, 32'd256);
    check("full_last_addr", {24'd0, last_addr}, 32'd255);
    check("full_start_cnt", start_cnt, 32'd1);
    check("full_q", exp_q.size(), 32'd0);

    // stall 10 cycles after HI byte -> timeout
    pulse_load();
    send_byte(8'd2, 0);
    send_byte(8'h77, 0);
    bus.rx_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("to_not_yet", {27'd0, err, dbg_state}, {27'd0, 1'b0, S_LO});
    @(posedge clock);
    #1;
    check("to_fired", {27'd0, err, dbg_state}, {27'd0, 1'b1, S_ERR});
    check("to_en", {31'd0, cpu_enable}, 32'd0);

    // stall 9 cycles then continue -> no error
    start_cnt = 0;
    pulse_load();
    send_byte(8'd1, 0);
    exp_q.push_back({8'd0, 16'h5AC3});
    send_byte(8'h5A, 0);
    bus.rx_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    send_byte(8'hC3, 0);
    send_byte(8'h99, 0);
    bus.rx_valid = 1'b0;
    wait_state("stall9_done", S_DONE, 20);
    check("stall9_flags", {done, err}, 32'b10);
    check("stall9_start", start_cnt, 32'd1);
    check("stall9_q", exp_q.size(), 32'd0);

    // random gaps and a load_req while busy
    src_q.delete();
    chk = 8'd0;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] w;
      w = 16'($urandom_range(0, 65535));
      src_q.push_back(w);
      chk = chk ^ w[15:8] ^ w[7:0];
    end
    start_cnt = 0;
    pulse_load();
    fork
      send_frame(8'd6, chk, 4);
      begin
        repeat (8) @(negedge clock);
        check("busy_at_req", {31'd0, busy}, 32'd1);
        pulse_load();
      end
    join
    wait_state("rand_done", S_DONE, 40);
    check("rand_start_cnt", start_cnt, 32'd1);
    check("rand_wc", {23'd0, word_cnt}, 32'd6);
    check("rand_q", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
